// File: rtl/alu_result_framer_if.sv
// Handshake bundle for alu_result_framer: upstream result word in, byte stream out.
interface alu_result_framer_if #(
    parameter int unsigned WORD_BYTES = 8
);
    logic [8*WORD_BYTES-1:0] result_i;
    logic [3:0]              nbytes_i;
    logic [7:0]              opcode_i;
    logic                    valid_i;
    logic                    ready_o;
    logic [7:0]              data_o;
    logic                    valid_o;
    logic                    ready_i;
    logic                    busy_o;

    // Framer side
    modport slave (
        input  result_i, nbytes_i, opcode_i, valid_i, ready_i,
        output ready_o, data_o, valid_o, busy_o
    );

    // Producer / consumer side
    modport master (
        output result_i, nbytes_i, opcode_i, valid_i, ready_i,
        input  ready_o, data_o, valid_o, busy_o
    );
endinterface

// File: rtl/alu_result_framer.sv
// Serializes an ALU result word LSB-first onto an 8-bit valid/ready stream.
// Define RESULT_HEADER_EN to prepend the 4-byte response header.
module alu_result_framer #(
    parameter int unsigned WORD_BYTES = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_result_framer_if.slave   bus
);
    localparam int unsigned W     = 8 * WORD_BYTES;
    localparam logic [3:0]  MAX_N = 4'(WORD_BYTES);

`ifdef RESULT_HEADER_EN
    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_DATA} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_DATA} state_t;
`endif

    state_t       state;
    logic [W-1:0] res_q;
    logic [3:0]   n_q;
    logic [3:0]   byte_idx;
    logic [3:0]   n_in_c;
    logic         xfer_c;
    logic         last_data_c;

`ifdef RESULT_HEADER_EN
    logic [7:0]   op_q;
    logic [1:0]   hdr_idx;
    logic [15:0]  len_c;
    assign len_c = 16'(n_q) + 16'd4;
`endif

    assign n_in_c      = (bus.nbytes_i > MAX_N) ? MAX_N : bus.nbytes_i;
    assign xfer_c      = bus.valid_o && bus.ready_i;
    assign last_data_c = (byte_idx == n_q - 4'd1);

    // Byte k of the captured word; out-of-range k yields zero.
    function automatic logic [7:0] byte_sel(input logic [W-1:0] w, input logic [3:0] k);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < int'(WORD_BYTES); i++) begin
            if (4'(i) == k) b = w[8*i +: 8];
        end
        return b;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            res_q       <= '0;
            n_q         <= '0;
            byte_idx    <= '0;
`ifdef RESULT_HEADER_EN
            op_q        <= '0;
            hdr_idx     <= '0;
`endif
            bus.ready_o <= 1'b0;
            bus.valid_o <= 1'b0;
            bus.data_o  <= 8'h00;
            bus.busy_o  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    bus.ready_o <= 1'b1;
                    if (bus.valid_i && bus.ready_o) begin
                        res_q    <= bus.result_i;
                        n_q      <= n_in_c;
                        byte_idx <= '0;
`ifdef RESULT_HEADER_EN
                        op_q        <= bus.opcode_i;
                        hdr_idx     <= '0;
                        state       <= S_HEADER;
                        bus.ready_o <= 1'b0;
                        bus.valid_o <= 1'b1;
                        bus.data_o  <= bus.opcode_i;
                        bus.busy_o  <= 1'b1;
`else
                        // Zero-length words carry nothing to send without a header.
                        if (n_in_c != 4'd0) begin
                            state       <= S_DATA;
                            bus.ready_o <= 1'b0;
                            bus.valid_o <= 1'b1;
                            bus.data_o  <= bus.result_i[7:0];
                            bus.busy_o  <= 1'b1;
                        end
`endif
                    end
                end
`ifdef RESULT_HEADER_EN
                S_HEADER: begin
                    if (xfer_c) begin
                        if (hdr_idx == 2'd3) begin
                            if (n_q != 4'd0) begin
                                state      <= S_DATA;
                                bus.data_o <= res_q[7:0];
                            end else begin
                                state       <= S_IDLE;
                                bus.valid_o <= 1'b0;
                                bus.data_o  <= 8'h00;
                                bus.busy_o  <= 1'b0;
                                bus.ready_o <= 1'b1;
                            end
                        end else begin
                            hdr_idx <= hdr_idx + 2'd1;
                            case (hdr_idx)
                                2'd0:    bus.data_o <= 8'h00;
                                2'd1:    bus.data_o <= len_c[7:0];
                                default: bus.data_o <= len_c[15:8];
                            endcase
                        end
                    end
                end
`endif
                S_DATA: begin
                    if (xfer_c) begin
                        if (last_data_c) begin
                            state       <= S_IDLE;
                            bus.valid_o <= 1'b0;
                            bus.data_o  <= 8'h00;
                            bus.busy_o  <= 1'b0;
                            bus.ready_o <= 1'b1;
                        end else begin
                            byte_idx   <= byte_idx + 4'd1;
                            bus.data_o <= byte_sel(res_q, byte_idx + 4'd1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_result_framer.md
# alu_result_framer

Downstream stage of the packet FSM: accepts one ALU result word per operation, with its opcode and valid-byte count, over a valid/ready handshake. Serializes it least-significant byte first onto an 8-bit valid/ready stream feeding the UART transmitter. Optionally prepends the 4-byte response header (opcode, reserved, length LSB, length MSB), which mirrors the request packet format.

## Interface
- WORD_BYTES, 8, width of the result word in bytes; legal range 1..8
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- result_i  input  8*WORD_BYTES  result word from ALU; byte 0 = result_i[7:0]
- nbytes_i  input  4  number of result bytes to send; clamped to WORD_BYTES
- opcode_i  input  8  opcode echoed in the header
- valid_i  input  1  result word valid (upstream)
- ready_o  output  1  framer can accept a word (to upstream)
- data_o  output  8  byte to UART TX
- valid_o  output  1  data_o valid
- ready_i  input  1  UART TX accepts byte
- busy_o  output  1  frame in progress (state != IDLE)

## Operation
- States: IDLE, HEADER (macro only), DATA.
- IDLE: ready_o=1, valid_o=0. On valid_i&&ready_o, capture result_i, opcode_i, and n = min(nbytes_i, WORD_BYTES) into registers.
  - If n==0 and the header is compiled out: word dropped, stay IDLE.
  - Otherwise go to HEADER (macro) or DATA.
- HEADER: emits 4 bytes in order: opcode, 0x00, len[7:0], len[15:8], where len = n+4 (16-bit, zero-extended). Byte index 0..3 is held in a 2-bit counter. After the handshake on index 3: go to DATA if n!=0, else go to IDLE.
- DATA: emits byte k = captured_result[8k+7:8k] for k = 0..n-1 (4-bit counter). After the handshake on k==n-1, go to IDLE.
- Byte handshake: a transfer occurs when valid_o&&ready_i. The byte counter advances only on a transfer.
- While valid_o&&!ready_i, data_o is held stable and valid_o stays high. No byte is ever dropped or repeated.
- ready_o is 0 in every state except IDLE. Upstream valid_i is ignored outside IDLE.
- Captured registers do not change outside IDLE, so upstream may change result_i freely after the capture handshake.

## Timing
- Reset values: ready_o=0 during the reset cycle and 1 the cycle after; valid_o=0, data_o=0x00, busy_o=0; counters=0; state IDLE.
- Reset mid-frame: the frame is abandoned and no further bytes are emitted. valid_o=0 starting in the cycle after rst is sampled.
- Capture at edge N; first byte has valid_o=1 in cycle N+1. valid_o and data_o are registered outputs.
- With ready_i held at 1: one byte per cycle, with no bubbles between header and data.
- After the final byte transfers at edge M: valid_o=0 and ready_o=1 in cycle M+1, so the next word can be captured at edge M+1.
- Frame occupancy with ready_i=1: n cycles (header out) or n+4 cycles (header in), plus 1 idle cycle between words.
- nbytes_i > WORD_BYTES: clamp to WORD_BYTES (e.g. 12 becomes 8).

## Configuration
- RESULT_HEADER_EN defined: HEADER state is present. Every accepted word produces a 4-byte header followed by n data bytes; n==0 yields a header-only frame with len=4.
- RESULT_HEADER_EN undefined: no HEADER state. Only the n data bytes are sent, and n==0 words are silently dropped.

## Test plan
- Header out; result=0x1122334455667788, n=8, ready_i=1 -> bytes 88,77,66,55,44,33,22,11 on 8 consecutive cycles starting 1 cycle after capture; then ready_o=1.
- Header in; opcode=0x02, result=0x00000000DEADBEEF, n=4 -> bytes 02,00,08,00,EF,BE,AD,DE; busy_o high for exactly 8 cycles.
- Backpressure; n=3, result=0xAABBCC, ready_i toggling 1,0,0,1,0,1 -> CC, BB, AA each transferred exactly once; data_o stable during stall cycles.
- Boundaries; nbytes_i=0 -> header out: nothing emitted, ready_o stays 1; header in: 04,00,04,00 only. nbytes_i=15 with WORD_BYTES=8 -> exactly 8 data bytes.
- Back-to-back words with valid_i held high -> second capture one cycle after the first frame's last transfer; no byte loss; ready_o low throughout each frame.
- rst asserted after 2 of 8 data bytes -> valid_o=0 the next cycle; a new word after reset produces a complete, correct frame.
